// File: rtl/bf_stream_scheduler.sv
// bf_stream_scheduler: joins the four 128-bit sample streams into lock-step
// beats, registers them toward the combiner and tags every beat with the
// weight snapshot that stays constant for the whole frame.
//
// state     | meaning
// ST_IDLE   | between frames; a pending weight commit may be applied
// ST_FRAME  | inside a frame; active weights frozen until the last beat
module bf_stream_scheduler #(
  parameter int DATA_W   = 128,
  parameter int WEIGHT_W = 9,
  parameter int FCNT_W   = 16
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic [DATA_W-1:0]     s00_tdata,
  input  logic                  s00_tvalid,
  input  logic                  s00_tlast,
  output logic                  s00_tready,
  input  logic [DATA_W-1:0]     s01_tdata,
  input  logic                  s01_tvalid,
  input  logic                  s01_tlast,
  output logic                  s01_tready,
  input  logic [DATA_W-1:0]     s20_tdata,
  input  logic                  s20_tvalid,
  input  logic                  s20_tlast,
  output logic                  s20_tready,
  input  logic [DATA_W-1:0]     s21_tdata,
  input  logic                  s21_tvalid,
  input  logic                  s21_tlast,
  output logic                  s21_tready,
  output logic [DATA_W-1:0]     m_tdata00,
  output logic [DATA_W-1:0]     m_tdata01,
  output logic [DATA_W-1:0]     m_tdata20,
  output logic [DATA_W-1:0]     m_tdata21,
  output logic [8*WEIGHT_W-1:0] m_weights,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [WEIGHT_W-1:0]   cfg_wdata,
  input  logic                  cfg_commit,
  output logic                  cfg_pending,
  output logic [FCNT_W-1:0]     frame_count,
  output logic                  align_err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;
  localparam int         BANK_W   = 8 * WEIGHT_W;

  logic [0:0]        state;
  logic [BANK_W-1:0] shadow_bank;
  logic [BANK_W-1:0] active_bank;
  logic              all_valid;
  logic              out_free;
  logic              accept;
  logic              lasts_mixed;
  logic              apply_pt;
  logic              commit_now;

  // Join: a beat is taken only when all four channels present data and the
  // output slot is free; held off entirely while in reset.
  always_comb begin
    all_valid   = s00_tvalid & s01_tvalid & s20_tvalid & s21_tvalid;
    out_free    = !m_tvalid | m_tready;
    accept      = resetn & all_valid & out_free;
    lasts_mixed = (s00_tlast ^ s01_tlast) | (s00_tlast ^ s20_tlast) |
                  (s00_tlast ^ s21_tlast);
    apply_pt    = ((state == ST_IDLE) & !accept) | (accept & s00_tlast);
    commit_now  = apply_pt & (cfg_commit | cfg_pending);
  end

  assign s00_tready = accept;
  assign s01_tready = accept;
  assign s20_tready = accept;
  assign s21_tready = accept;

  // Output register: load on accept, drop valid once the combiner takes it.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tdata00 <= '0;
      m_tdata01 <= '0;
      m_tdata20 <= '0;
      m_tdata21 <= '0;
      m_weights <= '0;
    end else if (accept) begin
      m_tvalid  <= 1'b1;
      m_tlast   <= s00_tlast;
      m_tdata00 <= s00_tdata;
      m_tdata01 <= s01_tdata;
      m_tdata20 <= s20_tdata;
      m_tdata21 <= s21_tdata;
      m_weights <= active_bank;
    end else if (m_tready) begin
      m_tvalid  <= 1'b0;
    end
  end

  // Frame tracking follows channel 00's tlast only.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else if (accept) begin
      state <= s00_tlast ? ST_IDLE : ST_FRAME;
    end
  end

  // Completed-frame counter and sticky tlast disagreement flag.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      frame_count <= '0;
      align_err   <= 1'b0;
    end else if (accept) begin
      if (s00_tlast) begin
        frame_count <= frame_count + {{(FCNT_W-1){1'b0}}, 1'b1};
      end
      if (lasts_mixed) begin
        align_err <= 1'b1;
      end
    end
  end

  // Weight banks: host writes the shadow any time; the copy to active happens
  // only at a frame boundary so one frame never mixes two weight sets. The
  // copy takes the shadow as it was before a same-cycle write.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      shadow_bank <= '0;
      active_bank <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_we) begin
        shadow_bank[int'(cfg_addr)*WEIGHT_W +: WEIGHT_W] <= cfg_wdata;
      end
      if (commit_now) begin
        active_bank <= shadow_bank;
        cfg_pending <= 1'b0;
      end else if (cfg_commit) begin
        cfg_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bf_stream_scheduler.sv
// Self-checking bench for bf_stream_scheduler: directed scenarios plus a
// randomized run, all compared against a behavioural reference model.
module tb_bf_stream_scheduler;

  localparam int DW = 128;
  localparam int WW = 9;
  localparam int FW = 16;

  logic CLK = 1'b0;
  logic resetn;
  logic [DW-1:0] s00_tdata, s01_tdata, s20_tdata, s21_tdata;
  logic s00_tvalid, s01_tvalid, s20_tvalid, s21_tvalid;
  logic s00_tlast, s01_tlast, s20_tlast, s21_tlast;
  logic s00_tready, s01_tready, s20_tready, s21_tready;
  logic [DW-1:0] m_tdata00, m_tdata01, m_tdata20, m_tdata21;
  logic [8*WW-1:0] m_weights;
  logic m_tvalid, m_tlast, m_tready;
  logic cfg_we, cfg_commit, cfg_pending, align_err;
  logic [2:0] cfg_addr;
  logic [WW-1:0] cfg_wdata;
  logic [FW-1:0] frame_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [WW-1:0] sh_m[8];
  logic [WW-1:0] act_m[8];
  logic pend_m, in_frame_m, mv_m, ml_m, al_m;
  logic [DW-1:0] md_m[4];
  logic [8*WW-1:0] mw_m;
  logic [FW-1:0] fc_m;
  logic [DW-1:0] delivered_q[$];

  bf_stream_scheduler #(.DATA_W(DW), .WEIGHT_W(WW), .FCNT_W(FW)) dut (
    .CLK(CLK), .resetn(resetn),
    .s00_tdata(s00_tdata), .s00_tvalid(s00_tvalid), .s00_tlast(s00_tlast), .s00_tready(s00_tready),
    .s01_tdata(s01_tdata), .s01_tvalid(s01_tvalid), .s01_tlast(s01_tlast), .s01_tready(s01_tready),
    .s20_tdata(s20_tdata), .s20_tvalid(s20_tvalid), .s20_tlast(s20_tlast), .s20_tready(s20_tready),
    .s21_tdata(s21_tdata), .s21_tvalid(s21_tvalid), .s21_tlast(s21_tlast), .s21_tready(s21_tready),
    .m_tdata00(m_tdata00), .m_tdata01(m_tdata01), .m_tdata20(m_tdata20), .m_tdata21(m_tdata21),
    .m_weights(m_weights), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .frame_count(frame_count), .align_err(align_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [8*WW-1:0] active_word();
    logic [8*WW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*WW +: WW] = act_m[i];
    return r;
  endfunction

  function automatic logic exp_ready();
    return resetn && s00_tvalid && s01_tvalid && s20_tvalid && s21_tvalid && (!mv_m || m_tready);
  endfunction

  task automatic set_valid(input logic v);
    s00_tvalid = v; s01_tvalid = v; s20_tvalid = v; s21_tvalid = v;
  endtask

  task automatic set_last(input logic l);
    s00_tlast = l; s01_tlast = l; s20_tlast = l; s21_tlast = l;
  endtask

  // One clock: model consumes the pre-edge inputs, then returns at negedge.
  task automatic tick();
    logic rst, acc, hs, mtr, last0, mixed, cm, we, ap;
    logic [DW-1:0] d[4];
    logic [2:0] a;
    logic [WW-1:0] wd;
    rst   = !resetn;
    acc   = exp_ready();
    hs    = resetn && mv_m && m_tready;
    mtr   = m_tready;
    last0 = s00_tlast;
    mixed = !((s00_tlast == s01_tlast) && (s00_tlast == s20_tlast) && (s00_tlast == s21_tlast));
    cm = cfg_commit; we = cfg_we; a = cfg_addr; wd = cfg_wdata;
    d[0] = s00_tdata; d[1] = s01_tdata; d[2] = s20_tdata; d[3] = s21_tdata;
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin sh_m[i] = '0; act_m[i] = '0; end
      pend_m = 0; in_frame_m = 0; mv_m = 0; ml_m = 0; al_m = 0; fc_m = '0; mw_m = '0;
      for (int i = 0; i < 4; i++) md_m[i] = '0;
    end else begin
      if (hs) delivered_q.push_back(md_m[0]);
      ap = (!in_frame_m && !acc) || (acc && last0);
      if (acc) begin
        for (int i = 0; i < 4; i++) md_m[i] = d[i];
        ml_m = last0; mw_m = active_word(); mv_m = 1;
        if (mixed) al_m = 1;
        if (last0) begin fc_m = fc_m + 1'b1; in_frame_m = 0; end
        else in_frame_m = 1;
      end else if (mtr) begin
        mv_m = 0;
      end
      if (ap && (cm || pend_m)) begin
        for (int i = 0; i < 8; i++) act_m[i] = sh_m[i];
        pend_m = 0;
      end else if (cm) begin
        pend_m = 1;
      end
      if (we) sh_m[a] = wd;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    resetn = 0; set_valid(1); m_tready = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++;
      if ({s00_tready, s01_tready, s20_tready, s21_tready} !== 4'b0000) begin
        errors++; $display("FAIL reset_tready: got %b want 0000", {s00_tready, s01_tready, s20_tready, s21_tready});
      end
    end
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_mvalid: got v=%b l=%b want 0 0", m_tvalid, m_tlast);
    end
    checks++;
    if (m_weights !== '0 || m_tdata00 !== '0) begin
      errors++; $display("FAIL reset_regs: weights %h data00 %h want 0", m_weights, m_tdata00);
    end
    checks++;
    if (frame_count !== '0 || cfg_pending !== 1'b0 || align_err !== 1'b0) begin
      errors++; $display("FAIL reset_status: fc %0d pend %b align %b want 0 0 0", frame_count, cfg_pending, align_err);
    end
    set_valid(0);
    resetn = 1;
    tick();
  endtask

  task automatic test_join();
    logic [DW-1:0] d[4];
    for (int i = 0; i < 4; i++) d[i] = rnd128();
    s00_tdata = d[0]; s01_tdata = d[1]; s20_tdata = d[2]; s21_tdata = d[3];
    set_last(1); m_tready = 1;
    s00_tvalid = 1; s01_tvalid = 1; s20_tvalid = 1; s21_tvalid = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({s00_tready, s01_tready, s20_tready, s21_tready} !== 4'b0000) begin
        errors++; $display("FAIL join_early_ready cyc %0d: got %b want 0000", c, {s00_tready, s01_tready, s20_tready, s21_tready});
      end
      tick();
    end
    s21_tvalid = 1;
    #1;
    checks++;
    if ({s00_tready, s01_tready, s20_tready, s21_tready} !== 4'b1111) begin
      errors++; $display("FAIL join_ready: got %b want 1111", {s00_tready, s01_tready, s20_tready, s21_tready});
    end
    tick();
    set_valid(0);
    checks++;
    if (m_tvalid !== 1'b1 || m_tlast !== 1'b1) begin
      errors++; $display("FAIL join_mvalid: got v=%b l=%b want 1 1", m_tvalid, m_tlast);
    end
    checks++;
    if (m_tdata00 !== d[0] || m_tdata01 !== d[1] || m_tdata20 !== d[2] || m_tdata21 !== d[3]) begin
      errors++; $display("FAIL join_data: got %h %h want %h %h", m_tdata00, m_tdata21, d[0], d[3]);
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++; $display("FAIL join_fcount: got %0d want 1", frame_count);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] bd[4][4];
    int b, cyc;
    logic [FW-1:0] fc0;
    for (int i = 0; i < 4; i++) for (int c = 0; c < 4; c++) bd[i][c] = rnd128();
    delivered_q.delete();
    fc0 = fc_m; b = 0; cyc = 0;
    while (delivered_q.size() < 4 && cyc < 40) begin
      m_tready = !(cyc >= 2 && cyc <= 4);
      set_valid(b < 4);
      if (b < 4) begin
        s00_tdata = bd[b][0]; s01_tdata = bd[b][1]; s20_tdata = bd[b][2]; s21_tdata = bd[b][3];
      end
      set_last(b == 3);
      #1;
      checks++;
      if (s00_tready !== ((b < 4) && (!m_tvalid || m_tready))) begin
        errors++; $display("FAIL bp_ready cyc %0d: got %b", cyc, s00_tready);
      end
      if (exp_ready()) b++;
      tick();
      if (m_tvalid === 1'b1 && delivered_q.size() < 4) begin
        checks++;
        if (m_tdata00 !== bd[delivered_q.size()][0] || m_tdata21 !== bd[delivered_q.size()][3] ||
            m_tlast !== (delivered_q.size() == 3)) begin
          errors++; $display("FAIL bp_hold cyc %0d: got %h last %b want %h", cyc, m_tdata00, m_tlast, bd[delivered_q.size()][0]);
        end
      end
      cyc++;
    end
    set_valid(0); m_tready = 1;
    checks++;
    if (delivered_q.size() != 4) begin
      errors++; $display("FAIL bp_timeout: delivered %0d want 4", delivered_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (delivered_q[i] !== bd[i][0]) begin
          errors++; $display("FAIL bp_order beat %0d: got %h want %h", i, delivered_q[i], bd[i][0]);
        end
      end
    end
    checks++;
    if (frame_count !== fc0 + 16'd1) begin
      errors++; $display("FAIL bp_fcount: got %0d want %0d", frame_count, fc0 + 16'd1);
    end
    tick();
  endtask

  task automatic test_mid_commit();
    m_tready = 1; set_valid(0);
    cfg_we = 1; cfg_addr = 3'd0; cfg_wdata = 9'h0FF;
    tick();
    cfg_we = 0;
    for (int k = 0; k < 8; k++) begin
      set_valid(1); set_last(k == 7);
      s00_tdata = rnd128(); s01_tdata = rnd128(); s20_tdata = rnd128(); s21_tdata = rnd128();
      cfg_commit = (k == 1);
      tick();
      cfg_commit = 0;
      checks++;
      if (m_tvalid !== 1'b1 || m_weights[WW-1:0] !== 9'h000) begin
        errors++; $display("FAIL midc_weight beat %0d: v=%b w00_r %h want 1 000", k + 1, m_tvalid, m_weights[WW-1:0]);
      end
      checks++;
      if (cfg_pending !== (k >= 1 && k <= 6)) begin
        errors++; $display("FAIL midc_pending beat %0d: got %b want %b", k + 1, cfg_pending, (k >= 1 && k <= 6));
      end
    end
    set_last(1);
    tick();
    set_valid(0);
    checks++;
    if (m_weights !== {63'd0, 9'h0FF}) begin
      errors++; $display("FAIL midc_next_frame: got %h want 0ff", m_weights);
    end
    tick();
  endtask

  task automatic test_idle_collision();
    m_tready = 1; set_valid(0); set_last(1);
    cfg_we = 1; cfg_addr = 3'd0; cfg_wdata = 9'h001;
    tick();
    cfg_wdata = 9'h003; cfg_commit = 1;
    tick();
    cfg_we = 0; cfg_commit = 0;
    checks++;
    if (cfg_pending !== 1'b0) begin
      errors++; $display("FAIL coll_pending: got %b want 0", cfg_pending);
    end
    set_valid(1);
    tick();
    set_valid(0);
    checks++;
    if (m_weights !== {63'd0, 9'h001}) begin
      errors++; $display("FAIL coll_active: got %h want 001", m_weights);
    end
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    set_valid(1);
    tick();
    set_valid(0);
    checks++;
    if (m_weights !== {63'd0, 9'h003}) begin
      errors++; $display("FAIL coll_shadow: got %h want 003", m_weights);
    end
    tick();
  endtask

  task automatic test_misalign();
    logic [FW-1:0] fc0;
    fc0 = fc_m; m_tready = 1;
    checks++;
    if (align_err !== 1'b0) begin
      errors++; $display("FAIL mis_pre: got %b want 0", align_err);
    end
    set_valid(1); set_last(1); s20_tlast = 0;
    tick();
    checks++;
    if (align_err !== 1'b1 || frame_count !== fc0 + 16'd1) begin
      errors++; $display("FAIL mis_flag: align %b fc %0d want 1 %0d", align_err, frame_count, fc0 + 16'd1);
    end
    set_last(0);
    tick();
    set_last(1);
    tick();
    set_valid(0);
    tick();
    checks++;
    if (align_err !== 1'b1 || frame_count !== fc0 + 16'd2) begin
      errors++; $display("FAIL mis_sticky: align %b fc %0d want 1 %0d", align_err, frame_count, fc0 + 16'd2);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      resetn     = ($urandom_range(0, 499) != 0);
      s00_tvalid = ($urandom_range(0, 3) != 0);
      s01_tvalid = ($urandom_range(0, 3) != 0);
      s20_tvalid = ($urandom_range(0, 3) != 0);
      s21_tvalid = ($urandom_range(0, 3) != 0);
      m_tready   = ($urandom_range(0, 3) != 0);
      set_last($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 30) == 0) s01_tlast = !s01_tlast;
      s00_tdata = rnd128(); s01_tdata = rnd128(); s20_tdata = rnd128(); s21_tdata = rnd128();
      cfg_we = ($urandom_range(0, 3) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_wdata = 9'($urandom_range(0, 511));
      cfg_commit = ($urandom_range(0, 9) == 0);
      #1;
      checks++;
      if (s00_tready !== exp_ready() || s21_tready !== exp_ready()) begin
        errors++; $display("FAIL rnd_ready cyc %0d: got %b want %b", c, s00_tready, exp_ready());
      end
      tick();
      checks++;
      if (m_tvalid !== mv_m) begin
        errors++; $display("FAIL rnd_mvalid cyc %0d: got %b want %b", c, m_tvalid, mv_m);
      end
      if (mv_m) begin
        checks++;
        if (m_tdata00 !== md_m[0] || m_tdata01 !== md_m[1] || m_tdata20 !== md_m[2] ||
            m_tdata21 !== md_m[3] || m_tlast !== ml_m || m_weights !== mw_m) begin
          errors++; $display("FAIL rnd_beat cyc %0d: got %h l%b w%h want %h l%b w%h", c, m_tdata00, m_tlast, m_weights, md_m[0], ml_m, mw_m);
        end
      end
      checks++;
      if (cfg_pending !== pend_m || frame_count !== fc_m || align_err !== al_m) begin
        errors++; $display("FAIL rnd_status cyc %0d: got p%b f%0d a%b want p%b f%0d a%b", c, cfg_pending, frame_count, align_err, pend_m, fc_m, al_m);
      end
    end
    resetn = 1; cfg_we = 0; cfg_commit = 0; set_valid(0); m_tready = 1;
    tick(); tick();
  endtask

  task automatic test_wrap();
    int n;
    n = 65536 - int'(fc_m);
    m_tready = 1; set_valid(1); set_last(1);
    for (int i = 0; i < n - 1; i++) tick();
    checks++;
    if (frame_count !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_max: got %h want ffff", frame_count);
    end
    tick();
    checks++;
    if (frame_count !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero: got %h want 0000", frame_count);
    end
    tick();
    set_valid(0);
    checks++;
    if (frame_count !== 16'h0001) begin
      errors++; $display("FAIL wrap_one: got %h want 0001", frame_count);
    end
    tick();
  endtask

  initial begin
    resetn = 0; m_tready = 1;
    s00_tdata = '0; s01_tdata = '0; s20_tdata = '0; s21_tdata = '0;
    set_valid(0); set_last(0);
    cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 0;
    mv_m = 0;
    @(negedge CLK);
    test_reset();
    test_join();
    test_backpressure();
    test_mid_commit();
    test_idle_collision();
    test_misalign();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
